mc_main_control: RTL and testbench

Multicycle MIPS main control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and mux select, and the 3-bit `ALUOp` bus consumed directly by the downstream ALU control block. Its `ALUOp` encoding must match that block exactly.

---
 rtl/mc_main_control_pkg.sv | 69 ++++++
 rtl/mc_ctrl_decode.sv | 79 +++++++
 rtl/mc_main_control.sv | 74 +++++++
 tb/tb_mc_main_control.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mc_main_control_pkg.sv
// Shared definitions for the multicycle MIPS main control: opcodes, ALUOp
// encodings (must match ALU control), state encodings and the control word.
package mc_main_control_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH.
    function automatic state_e decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:                      return S_MEMADR;
            OP_R:                              return S_RTYPE;
            OP_BEQ:                            return S_BRANCH;
            OP_J:                              return S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_IEXEC;
            default:                           return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state + opcode to control-word decoder (Moore outputs).
module mc_ctrl_decode
    import mc_main_control_pkg::*;
(
    input  logic [3:0]        i_state,
    input  logic [5:0]        i_op,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_t w_c;

    always_comb begin
        w_c = '0;
        case (state_e'(i_state))
            S_FETCH: begin
                w_c.mem_read  = 1'b1;
                w_c.ir_write  = 1'b1;
                w_c.alu_src_b = 2'b01;
                w_c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                w_c.alu_src_b = 2'b11;
                w_c.illegal   = (decode_target(i_op) == S_FETCH);
            end
            S_MEMADR: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_c.mem_read = 1'b1;
                w_c.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_c.reg_write  = 1'b1;
                w_c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_c.mem_write = 1'b1;
                w_c.iord      = 1'b1;
            end
            S_RTYPE: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                w_c.reg_write = 1'b1;
                w_c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_c.alu_src_a     = 1'b1;
                w_c.alu_op        = ALU_SUB;
                w_c.pc_write_cond = 1'b1;
                w_c.pc_src        = 2'b01;
            end
            S_JUMP: begin
                w_c.pc_write = 1'b1;
                w_c.pc_src   = 2'b10;
            end
            S_IEXEC: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = 2'b10;
                w_c.imm_zext  = (i_op == OP_ANDI) || (i_op == OP_ORI);
                case (i_op)
                    OP_ANDI: w_c.alu_op = ALU_AND;
                    OP_ORI:  w_c.alu_op = ALU_OR;
                    OP_SLTI: w_c.alu_op = ALU_SLT;
                    default: w_c.alu_op = ALU_ADD;
                endcase
            end
            S_IWB: begin
                w_c.reg_write = 1'b1;
            end
            default: w_c = '0;
        endcase
    end

    assign o_ctrl = w_c;

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// reset gating of the decoded control word.
module mc_main_control
    import mc_main_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ImmZext,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       Illegal
);

    state_e            r_state;
    state_e            w_next;
    logic [CTRL_W-1:0] w_ctrl_raw;
    ctrl_t             w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = decode_target(Op);
            S_MEMADR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_RTYPE:  w_next = S_ALUWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state (r_state),
        .i_op    (Op),
        .o_ctrl  (w_ctrl_raw)
    );

    // Reset kills outputs in the same cycle so an aborted instruction never writes back.
    assign w_ctrl = reset ? '0 : ctrl_t'(w_ctrl_raw);

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.iord;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ImmZext     = w_ctrl.imm_zext;
    assign PCSrc       = w_ctrl.pc_src;
    assign ALUOp       = w_ctrl.alu_op;
    assign Illegal     = w_ctrl.illegal;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: per-instruction expected output sequences built
// from the opcode's cycle recipe, checked every cycle, with random resets.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ImmZext, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmZext(ImmZext),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .Illegal(Illegal)
    );

    // Observed outputs flattened in a fixed order for comparison.
    logic [18:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ImmZext,
                  PCSrc, ALUOp, Illegal};

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mk(
        input bit pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
        input bit [1:0] asb, input bit zx, input bit [1:0] pcs,
        input bit [2:0] aop, input bit ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, zx, pcs, aop, ill};
    endfunction

    // Expected output word for every cycle of one instruction, FETCH first.
    function automatic void recipe(input logic [5:0] op, output logic [18:0] q[$]);
        logic [18:0] fetch, dec, dec_ill;
        fetch   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,0,2'b00,3'b000,0);
        dec     = mk(0,0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b000,0);
        dec_ill = mk(0,0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b000,1);
        q = {};
        q.push_back(fetch);
        case (op)
            6'b100011: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b000,0),
                            mk(0,0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0),
                            mk(0,0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,3'b000,0)};
            6'b101011: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b000,0),
                            mk(0,0,1,0,1,0,0,0,0,0,2'b00,0,2'b00,3'b000,0)};
            6'b000000: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b010,0),
                            mk(0,0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,3'b000,0)};
            6'b000100: q = {q, dec,
                            mk(0,1,0,0,0,0,0,0,0,1,2'b00,0,2'b01,3'b001,0)};
            6'b000010: q = {q, dec,
                            mk(1,0,0,0,0,0,0,0,0,0,2'b00,0,2'b10,3'b000,0)};
            6'b001000: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b000,0),
                            mk(0,0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,3'b000,0)};
            6'b001100: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b100,0),
                            mk(0,0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,3'b000,0)};
            6'b001101: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b110,0),
                            mk(0,0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,3'b000,0)};
            6'b001010: q = {q, dec,
                            mk(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b111,0),
                            mk(0,0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,3'b000,0)};
            default:   q.push_back(dec_ill);
        endcase
    endfunction

    // Run one instruction; rst_at >= 0 raises reset during that cycle, aborting it.
    task automatic run_instr(input logic [5:0] op, input int rst_at);
        logic [18:0] q[$];
        recipe(op, q);
        for (int i = 0; i < q.size(); i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk($sformatf("reset op=%06b c%0d", op, i + 1), obs, 19'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            Op = (i == 0) ? 6'($urandom) : op;
            @(negedge clk);
            chk($sformatf("op=%06b c%0d", op, i + 1), obs, q[i]);
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] legal_ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

    initial begin
        reset = 1'b1;
        Op    = 6'b000000;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset state", obs, 19'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(6'b100011, -1);
        run_instr(6'b000000, -1);
        run_instr(6'b001100, -1);
        run_instr(6'b001101, -1);
        run_instr(6'b001010, -1);
        run_instr(6'b001000, -1);
        run_instr(6'b000100, -1);
        run_instr(6'b000010, -1);
        run_instr(6'b111111, -1);
        run_instr(6'b101011, 3);
        run_instr(6'b100011, 4);
        run_instr(6'b000000, -1);

        for (int k = 0; k < 400; k++) begin
            logic [5:0] op;
            int         ra;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
